imem_loader: RTL and testbench

//  Writer side of instruction memory: receives a program image as a byte stream (UART RX, valid/ready)
//  and writes 32-bit words into imem while holding the CPU (PC register, fetch) in reset.

---
 rtl/loader_defs_pkg.sv | 19 +
 rtl/imem_loader_byte_to_word.sv | 37 +++
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_defs_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and frame constants.
package loader_defs_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        StWaitSync,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned LEN_W             = 16;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Assembles four little-endian bytes into a 32-bit word; pulses word_valid on the 4th byte.
module imem_loader_byte_to_word
    import loader_defs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_idx;
    logic [23:0] r_bytes;   // first three bytes, byte 0 ends up in [7:0]

    // Shift bytes in from the top so byte k lands in bits [8k+7:8k] of the finished word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_bytes <= '0;
        end else if (i_clear) begin
            r_idx   <= '0;
            r_bytes <= '0;
        end else if (i_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_bytes <= {i_byte, r_bytes[23:8]};
        end
    end

    // Word is complete combinationally on the 4th byte
    always_comb begin
        o_word       = {i_byte, r_bytes};
        o_word_valid = i_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/imem_loader.sv
// Writes a checksummed byte-stream program image into imem while holding the CPU in reset.
module imem_loader
    import loader_defs_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned BASE_ADDR      = 0,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam int unsigned       CAPACITY = 32'd1 << ADDR_W;

    state_e            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [7:0]        r_csum;
    logic [31:0]       r_timer;
    logic              r_rx_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_accept;
    logic              w_is_sync;
    logic              w_in_frame;
    logic              w_timeout;
    logic              w_b2w_clear;
    logic              w_b2w_valid;
    logic [LEN_W-1:0]  w_len;
    logic [31:0]       w_timer_next;
    logic [31:0]       w_word;
    logic              w_word_valid;

    // Handshake, frame decode and idle-timeout detection
    always_comb begin
        w_accept     = i_rx_valid && r_rx_ready;
        w_is_sync    = (i_rx_data == SYNC_BYTE);
        w_in_frame   = (r_state == StLenLo) || (r_state == StLenHi) ||
                       (r_state == StData)  || (r_state == StCsum);
        w_len        = {i_rx_data, r_len[7:0]};
        w_timer_next = r_timer + 32'd1;
        // An accepted byte in the expiry cycle beats the timeout
        w_timeout    = (TIMEOUT_CYCLES != 0) && w_in_frame && !w_accept &&
                       (w_timer_next == TIMEOUT_CYCLES);
        w_b2w_clear  = w_accept && w_is_sync &&
                       ((r_state == StWaitSync) || (r_state == StError));
        w_b2w_valid  = w_accept && (r_state == StData);
    end

    imem_loader_byte_to_word u_byte_to_word (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_b2w_clear),
        .i_valid      (w_b2w_valid),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Frame FSM with counters, checksum and registered imem write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StWaitSync;
            r_len        <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_timer      <= '0;
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= BASE;
            r_imem_wdata <= '0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            if (!w_in_frame || w_accept) begin
                r_timer <= '0;
            end else begin
                r_timer <= w_timer_next;
            end

            if (w_timeout) begin
                r_state    <= StError;
                r_load_err <= 1'b1;
            end else begin
                unique case (r_state)
                    StWaitSync, StError: begin
                        if (w_accept && w_is_sync) begin
                            r_state    <= StLenLo;
                            r_csum     <= '0;
                            r_idx      <= '0;
                            r_load_err <= 1'b0;
                        end
                    end
                    StLenLo: begin
                        if (w_accept) begin
                            r_len[7:0] <= i_rx_data;
                            r_csum     <= r_csum ^ i_rx_data;
                            r_state    <= StLenHi;
                        end
                    end
                    StLenHi: begin
                        if (w_accept) begin
                            r_len  <= w_len;
                            r_csum <= r_csum ^ i_rx_data;
                            if (w_len == '0) begin
                                r_state <= StCsum;
                            end else if (32'(w_len) > CAPACITY) begin
                                r_state    <= StError;
                                r_load_err <= 1'b1;
                            end else begin
                                r_state <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (w_accept) begin
                            r_csum <= r_csum ^ i_rx_data;
                            if (w_word_valid) begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= BASE + r_idx[ADDR_W-1:0];
                                r_imem_wdata <= w_word;
                                r_idx        <= r_idx + 16'd1;
                                if ((r_idx + 16'd1) == r_len) begin
                                    r_state <= StCsum;
                                end
                            end
                        end
                    end
                    StCsum: begin
                        if (w_accept) begin
                            if (i_rx_data == r_csum) begin
                                r_state     <= StDone;
                                r_cpu_hold  <= 1'b0;
                                r_load_done <= 1'b1;
                                r_rx_ready  <= 1'b0;
                            end else begin
                                r_state    <= StError;
                                r_load_err <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                    end
                    default: begin
                        r_state <= StWaitSync;
                    end
                endcase
            end
        end
    end

    // Registered outputs
    always_comb begin
        o_rx_ready   = r_rx_ready;
        o_imem_we    = r_imem_we;
        o_imem_addr  = r_imem_addr;
        o_imem_wdata = r_imem_wdata;
        o_cpu_hold   = r_cpu_hold;
        o_load_done  = r_load_done;
        o_load_err   = r_load_err;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected imem writes, a monitor pops and compares.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_cpu_hold;
    logic              o_load_done;
    logic              o_load_err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .BASE_ADDR      (0),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_hold   (o_cpu_hold),
        .o_load_done  (o_load_done),
        .o_load_err   (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic hold, input logic done,
                                input logic err, input logic ready);
        check({name, " cpu_hold"},  32'(o_cpu_hold),  32'(hold));
        check({name, " load_done"}, 32'(o_load_done), 32'(done));
        check({name, " load_err"},  32'(o_load_err),  32'(err));
        check({name, " rx_ready"},  32'(o_rx_ready),  32'(ready));
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Every imem write must match the oldest outstanding expectation
    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (o_imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none",
                             o_imem_addr, o_imem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("write_addr", 32'(o_imem_addr), 32'(w.addr));
                    check("write_data", o_imem_wdata, w.data);
                end
            end
        end
    endtask

    // Inputs change on negedge; a byte is held across one posedge where rx_ready is high
    task automatic send_byte(input logic [7:0] b);
        int waits;
        waits      = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!o_rx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte: rx_ready got 0 required 1");
        end
        @(negedge clk);
    endtask

    task automatic send_q();
        foreach (byte_q[i]) send_byte(byte_q[i]);
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        i_rx_valid = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);

        // Reset values
        check_status("reset", 1'b1, 1'b0, 1'b0, 1'b1);
        check("reset imem_addr", 32'(o_imem_addr), 32'd0);
        check("reset imem_wdata", o_imem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Garbage then valid two-word frame; checksum 02^00^13^00^00^00^93^00^10^00 = 0x92
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0010_0093);
        byte_q = '{8'h11, 8'h22, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00};
        send_q();
        check_status("pre_csum", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h92);
        i_rx_valid = 1'b0;
        check_status("frame_ok", 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_status("done_sticky", 1'b0, 1'b1, 1'b0, 1'b0);

        // Bad checksum, then recovery with a one-word frame (01^00^EF^BE^AD^DE = 0x23)
        apply_reset();
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0010_0093);
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        send_q();
        check_status("bad_csum", 1'b1, 1'b0, 1'b1, 1'b1);
        byte_q = '{8'h33, 8'h44};
        send_q();
        check_status("err_discard", 1'b1, 1'b0, 1'b1, 1'b1);
        expect_write(2'd0, 32'hDEAD_BEEF);
        byte_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_q();
        check_status("err_restart", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h23);
        i_rx_valid = 1'b0;
        check_status("recovered", 1'b0, 1'b1, 1'b0, 1'b0);

        // Zero-length frame
        apply_reset();
        byte_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        check_status("len_zero", 1'b0, 1'b1, 1'b0, 1'b0);

        // Oversize: capacity is 4 words
        apply_reset();
        byte_q = '{8'hA5, 8'h05, 8'h00};
        send_q();
        check_status("oversize", 1'b1, 1'b0, 1'b1, 1'b1);
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_q();
        check_status("oversize_tail", 1'b1, 1'b0, 1'b1, 1'b1);

        // Exactly capacity: bytes 01..10 XOR to 0x10, with LEN_LO 0x04 gives 0x14
        apply_reset();
        expect_write(2'd0, 32'h0403_0201);
        expect_write(2'd1, 32'h0807_0605);
        expect_write(2'd2, 32'h0C0B_0A09);
        expect_write(2'd3, 32'h100F_0E0D);
        byte_q = '{8'hA5, 8'h04, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h14};
        send_q();
        check_status("full_capacity", 1'b0, 1'b1, 1'b0, 1'b0);

        // Stall of 16 idle cycles after the 2nd data byte expires the timeout
        apply_reset();
        byte_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_q();
        idle(16);
        check_status("timeout_16", 1'b1, 1'b0, 1'b1, 1'b1);

        // Stall of 15 does not; frame completes (01^11^22^33^44 = 0x45)
        apply_reset();
        expect_write(2'd0, 32'h4433_2211);
        byte_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_q();
        idle(15);
        check_status("stall_15", 1'b1, 1'b0, 1'b0, 1'b1);
        byte_q = '{8'h33, 8'h44, 8'h45};
        send_q();
        check_status("stall_15_done", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while the 3rd data byte is on the bus drops the partial word
        apply_reset();
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_q();
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_status("mid_reset", 1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_reset imem_addr", 32'(o_imem_addr), 32'd0);
        i_rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0010_0093);
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        send_q();
        check_status("reload", 1'b0, 1'b1, 1'b0, 1'b0);

        idle(4);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
